// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: stage register fields in, stall/freeze/forward controls out.
// Pure wiring, no latency; the pipeline side (master) drives stage state.
// No handshake: outputs follow the inputs within the same cycle.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs, id_rt;
    logic             id_use_rs, id_use_rt;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic             ex_reg_w, ex_mem_r;
    logic [4:0]       mem_rd;
    logic             mem_reg_w, mem_req, mem_ready;
    logic [4:0]       wb_rd;
    logic             wb_reg_w;
    logic             stall, idex_bubble, freeze;
    logic [1:0]       fwd_a, fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles, freeze_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
               ex_rs, ex_rt, ex_rd, ex_reg_w, ex_mem_r,
               mem_rd, mem_reg_w, mem_req, mem_ready,
               wb_rd, wb_reg_w,
        input  stall, idex_bubble, freeze, fwd_a, fwd_b, halted,
               stall_cycles, freeze_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
               ex_rs, ex_rt, ex_rd, ex_reg_w, ex_mem_r,
               mem_rd, mem_reg_w, mem_req, mem_ready,
               wb_rd, wb_reg_w,
        output stall, idex_bubble, freeze, fwd_a, fwd_b, halted,
               stall_cycles, freeze_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, EX forwarding, memory-wait freeze and sticky timeout halt.
// Latency: stall/bubble/freeze/fwd are combinational (0 cycles); state and counters registered.
// Backpressure: freeze holds the whole pipe while mem_ready is low; HAZARD_PERF_EN adds perf counters.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              freeze_c, load_use, stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze_c     = 1'b0;
        case (state)
            RUN: begin
                freeze_c = hz.mem_req && !hz.mem_ready;
                if (freeze_c) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                freeze_c = !hz.mem_ready;
                if (hz.mem_ready)
                    state_nxt = RUN;
                else if (wait_cnt == WAIT_LIM)
                    state_nxt = HALT;
                else
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
            HALT:    freeze_c = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    assign load_use = hz.ex_mem_r && hz.ex_reg_w && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

    // A frozen pipe cannot swallow a bubble, so freeze masks it.
    assign stall_c        = freeze_c || load_use;
    assign hz.stall       = stall_c;
    assign hz.idex_bubble = load_use && !freeze_c;
    assign hz.freeze      = freeze_c;
    assign hz.halted      = (state == HALT);

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_rd, input logic m_w,
                                           input logic [4:0] w_rd, input logic w_w);
        if (m_w && (m_rd != 5'd0) && (m_rd == src))
            return 2'b01;
        else if (w_w && (w_rd != 5'd0) && (w_rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign hz.fwd_a = fwd_sel(hz.ex_rs, hz.mem_rd, hz.mem_reg_w, hz.wb_rd, hz.wb_reg_w);
    assign hz.fwd_b = fwd_sel(hz.ex_rt, hz.mem_rd, hz.mem_reg_w, hz.wb_rd, hz.wb_reg_w);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, freeze_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall_c && !freeze_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (freeze_c && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cycles  = stall_cnt;
    assign hz.freeze_cycles = freeze_cnt;
`else
    assign hz.stall_cycles  = '0;
    assign hz.freeze_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();

    pipeline_hazard_ctrl #(.WAIT_MAX(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string      nm;
        logic       st, bb, fz;
        logic [1:0] fa, fb;
        logic       hl;
        int         sc, fc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Counter expectation of -1 means "do not compare this cycle".
    task automatic expect_out(input string nm, input logic st, input logic bb, input logic fz,
                              input logic [1:0] fa, input logic [1:0] fb, input logic hl,
                              input int sc = -1, input int fc = -1);
        exp_t e;
        e.nm = nm; e.st = st; e.bb = bb; e.fz = fz;
        e.fa = fa; e.fb = fb; e.hl = hl;
        e.sc = (sc < 0) ? -1 : (PERF ? sc : 0);
        e.fc = (fc < 0) ? -1 : (PERF ? fc : 0);
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk({e.nm, ".stall"},  32'(hz.stall),       32'(e.st));
                chk({e.nm, ".bubble"}, 32'(hz.idex_bubble), 32'(e.bb));
                chk({e.nm, ".freeze"}, 32'(hz.freeze),      32'(e.fz));
                chk({e.nm, ".fwd_a"},  32'(hz.fwd_a),       32'(e.fa));
                chk({e.nm, ".fwd_b"},  32'(hz.fwd_b),       32'(e.fb));
                chk({e.nm, ".halted"}, 32'(hz.halted),      32'(e.hl));
                if (e.sc >= 0) chk({e.nm, ".stall_cycles"},  32'(hz.stall_cycles),  e.sc);
                if (e.fc >= 0) chk({e.nm, ".freeze_cycles"}, 32'(hz.freeze_cycles), e.fc);
            end
        end
    end

    task automatic set_idle();
        hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
        hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_rd = '0; hz.ex_reg_w = 1'b0; hz.ex_mem_r = 1'b0;
        hz.mem_rd = '0; hz.mem_reg_w = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        hz.wb_rd = '0; hz.wb_reg_w = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic load_use_rs();
        hz.ex_mem_r = 1'b1; hz.ex_reg_w = 1'b1; hz.ex_rd = 5'd5;
        hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
    endtask

    initial begin : stim
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state with idle inputs
        nxt(); rst = 1'b0;
        expect_out("reset", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Load-use detection
        nxt(); load_use_rs();
        expect_out("lu_rs", 1, 1, 0, 2'b00, 2'b00, 0, 0, 0);
        nxt(); load_use_rs(); hz.id_use_rs = 1'b0;
        expect_out("lu_unused", 0, 0, 0, 2'b00, 2'b00, 0, 1, 0);
        nxt(); hz.ex_mem_r = 1'b1; hz.ex_reg_w = 1'b1; hz.ex_rd = 5'd5;
        hz.id_rt = 5'd5; hz.id_use_rt = 1'b1;
        expect_out("lu_rt", 1, 1, 0, 2'b00, 2'b00, 0, 1, 0);
        nxt(); hz.ex_mem_r = 1'b1; hz.ex_reg_w = 1'b1; hz.ex_rd = 5'd0;
        hz.id_rs = 5'd0; hz.id_use_rs = 1'b1;
        expect_out("lu_r0", 0, 0, 0, 2'b00, 2'b00, 0, 2, 0);
        nxt(); load_use_rs(); hz.ex_reg_w = 1'b0;
        expect_out("lu_nowrite", 0, 0, 0, 2'b00, 2'b00, 0, 2, 0);

        // Forwarding priority and register 0
        nxt(); hz.ex_rs = 5'd3; hz.ex_rt = 5'd7; hz.mem_rd = 5'd3; hz.wb_rd = 5'd3;
        hz.mem_reg_w = 1'b1; hz.wb_reg_w = 1'b1;
        expect_out("fwd_mem", 0, 0, 0, 2'b01, 2'b00, 0);
        nxt(); hz.ex_rs = 5'd3; hz.ex_rt = 5'd7; hz.mem_rd = 5'd3; hz.wb_rd = 5'd3;
        hz.wb_reg_w = 1'b1;
        expect_out("fwd_wb", 0, 0, 0, 2'b10, 2'b00, 0);
        nxt(); hz.mem_rd = 5'd3; hz.wb_rd = 5'd3; hz.wb_reg_w = 1'b1;
        expect_out("fwd_rs0", 0, 0, 0, 2'b00, 2'b00, 0);
        nxt(); hz.mem_reg_w = 1'b1; hz.wb_reg_w = 1'b1;
        expect_out("fwd_r0", 0, 0, 0, 2'b00, 2'b00, 0);
        nxt(); hz.ex_rs = 5'd4; hz.ex_rt = 5'd9; hz.mem_rd = 5'd4; hz.wb_rd = 5'd9;
        hz.mem_reg_w = 1'b1; hz.wb_reg_w = 1'b1;
        expect_out("fwd_split", 0, 0, 0, 2'b01, 2'b10, 0);

        // Memory wait: 4 cycles not ready, then ready
        for (int i = 0; i < 4; i++) begin
            nxt(); hz.mem_req = 1'b1;
            expect_out($sformatf("mw_wait%0d", i), 1, 0, 1, 2'b00, 2'b00, 0);
        end
        nxt(); hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        expect_out("mw_ready", 0, 0, 0, 2'b00, 2'b00, 0, 2, 4);
        nxt();
        expect_out("mw_run", 0, 0, 0, 2'b00, 2'b00, 0, 2, 4);

        // Load-use overlapping a memory wait
        nxt(); load_use_rs(); hz.mem_req = 1'b1;
        expect_out("ov_frz0", 1, 0, 1, 2'b00, 2'b00, 0);
        nxt(); load_use_rs(); hz.mem_req = 1'b1;
        expect_out("ov_frz1", 1, 0, 1, 2'b00, 2'b00, 0);
        nxt(); load_use_rs(); hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        expect_out("ov_ready", 1, 1, 0, 2'b00, 2'b00, 0);
        nxt(); load_use_rs();
        expect_out("ov_after", 1, 1, 0, 2'b00, 2'b00, 0);
        nxt();
        expect_out("ov_idle", 0, 0, 0, 2'b00, 2'b00, 0, 4, 6);

        // Reset in the second MEM_WAIT cycle
        nxt(); hz.mem_req = 1'b1;
        expect_out("rmw_req", 1, 0, 1, 2'b00, 2'b00, 0);
        nxt(); hz.mem_req = 1'b1;
        expect_out("rmw_w1", 1, 0, 1, 2'b00, 2'b00, 0);
        nxt(); hz.mem_req = 1'b1; rst = 1'b1;
        expect_out("rmw_w2", 1, 0, 1, 2'b00, 2'b00, 0, 4, 8);
        nxt(); rst = 1'b0;
        expect_out("rmw_after", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Timeout at WAIT_MAX=8
        nxt(); hz.mem_req = 1'b1;
        expect_out("to_req", 1, 0, 1, 2'b00, 2'b00, 0);
        for (int i = 1; i <= 8; i++) begin
            nxt(); hz.mem_req = 1'b1;
            expect_out($sformatf("to_wait%0d", i), 1, 0, 1, 2'b00, 2'b00, 0);
        end
        nxt(); hz.mem_req = 1'b1;
        expect_out("to_halt", 1, 0, 1, 2'b00, 2'b00, 1);
        nxt(); hz.mem_ready = 1'b1;
        expect_out("to_ready_ign", 1, 0, 1, 2'b00, 2'b00, 1);
        nxt(); load_use_rs();
        expect_out("to_halt_lu", 1, 0, 1, 2'b00, 2'b00, 1, 0, 11);
        nxt(); rst = 1'b1;
        expect_out("to_rst", 1, 0, 1, 2'b00, 2'b00, 1);
        nxt(); rst = 1'b0;
        expect_out("to_cleared", 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // mem_ready arriving exactly when the count reaches WAIT_MAX
        nxt(); hz.mem_req = 1'b1;
        expect_out("edge_req", 1, 0, 1, 2'b00, 2'b00, 0);
        for (int i = 1; i <= 7; i++) begin
            nxt(); hz.mem_req = 1'b1;
            expect_out($sformatf("edge_wait%0d", i), 1, 0, 1, 2'b00, 2'b00, 0);
        end
        nxt(); hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        expect_out("edge_ready", 0, 0, 0, 2'b00, 2'b00, 0);
        nxt();
        expect_out("edge_run", 0, 0, 0, 2'b00, 2'b00, 0, 0, 8);

        nxt();
        nxt();
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
